debouncer_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_channel.sv | 91 +++++++++
 rtl/debouncer_multi.sv | 41 ++++
 tb/tb_debouncer_multi.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the debouncer family.
package debounce_pkg;

    localparam int DEB_N_STABLE_DEF = 50000;
    localparam int DEB_SYNC_DEF     = 2;

    // Counter width that never collapses to zero bits for tiny limits.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stable-time counter, edge pulses and
// optional long-press detection.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int N_STABLE    = DEB_N_STABLE_DEF,
    parameter int SYNC_STAGES = DEB_SYNC_DEF,
    parameter int HOLD_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_s_n,
    input  logic s_in,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam int               CNT_W   = clog2_min1(N_STABLE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_STABLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syn;
    logic [CNT_W-1:0]       cnt;
    logic                   state;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk) begin
        if (!rst_s_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], s_in};
        end
    end

    assign syn = sync_q[SYNC_STAGES-1];

    // Any return to the committed level restarts the stable-time count.
    always_ff @(posedge clk) begin
        if (!rst_s_n) begin
            cnt   <= '0;
            state <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (syn == state) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                state <= syn;
                rise  <= syn;
                fall  <= ~syn;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dout = state;

    if (HOLD_CYCLES > 0) begin : g_hold
        localparam int               HLD_W   = clog2_min1(HOLD_CYCLES + 1);
        localparam logic [HLD_W-1:0] HLD_MAX = HLD_W'(HOLD_CYCLES);

        logic [HLD_W-1:0] hcnt;
        logic             hold_q;

        // hcnt saturates, so the pulse fires once per press.
        always_ff @(posedge clk) begin
            if (!rst_s_n) begin
                hcnt   <= '0;
                hold_q <= 1'b0;
            end else begin
                hold_q <= state && (hcnt == HLD_MAX - 1'b1);
                if (!state) begin
                    hcnt <= '0;
                end else if (hcnt != HLD_MAX) begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end

        assign hold = hold_q;
    end else begin : g_no_hold
        assign hold = 1'b0;
    end

endmodule

// File: rtl/debouncer_multi.sv
// N independent debounced inputs with optional idle-high polarity correction.
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int N_STABLE    = DEB_N_STABLE_DEF,
    parameter int SYNC_STAGES = DEB_SYNC_DEF,
    parameter int HOLD_CYCLES = 0,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic            clk,
    input  logic            rst_s_n,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] hold
);

    logic [N_CH-1:0] s_in;

    // Internally a pressed input always reads as 1.
    assign s_in = din ^ {N_CH{ACTIVE_LOW}};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .N_STABLE    (N_STABLE),
            .SYNC_STAGES (SYNC_STAGES),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst_s_n (rst_s_n),
            .s_in    (s_in[i]),
            .dout    (dout[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .hold    (hold[i])
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench: reset, clean press, glitch rejection, long press, mid-count
// reset, and idle-high polarity on a second instance.
module tb_debouncer_multi;

    logic       clk = 1'b0;
    logic       rst_s_n;
    logic [1:0] din, din_al;
    logic [1:0] dout, rise, fall, hold;
    logic [1:0] dout_al, rise_al, fall_al, hold_al;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    debouncer_multi #(
        .N_CH(2), .N_STABLE(4), .SYNC_STAGES(2), .HOLD_CYCLES(6), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_s_n(rst_s_n), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .hold(hold)
    );

    debouncer_multi #(
        .N_CH(2), .N_STABLE(4), .SYNC_STAGES(2), .HOLD_CYCLES(0), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_s_n(rst_s_n), .din(din_al),
        .dout(dout_al), .rise(rise_al), .fall(fall_al), .hold(hold_al)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n ticks: outputs idle until the last one, which must show the commit.
    task automatic expect_commit(input string tag, input bit al, input int n,
                                 input logic [1:0] d_before, input logic [1:0] d_after,
                                 input logic [1:0] r_exp, input logic [1:0] f_exp);
        logic [1:0] d, r, f, h;
        for (int i = 1; i <= n; i++) begin
            tick();
            d = al ? dout_al : dout;
            r = al ? rise_al : rise;
            f = al ? fall_al : fall;
            h = al ? hold_al : hold;
            check({tag, " hold"}, h, 2'b00);
            if (i < n) begin
                check({tag, " dout early"}, d, d_before);
                check({tag, " edges early"}, {r, f}, 4'h0);
            end else begin
                check({tag, " dout"}, d, d_after);
                check({tag, " rise"}, r, r_exp);
                check({tag, " fall"}, f, f_exp);
            end
        end
    endtask

    task automatic expect_hold(input string tag, input int n, input logic [1:0] h_exp);
        for (int i = 1; i <= n; i++) begin
            tick();
            check({tag, " hold"}, hold, (i == n) ? h_exp : 2'b00);
        end
    endtask

    task automatic quiet(input string tag, input int n, input logic [1:0] d_exp);
        for (int i = 1; i <= n; i++) begin
            tick();
            check({tag, " dout"}, dout, d_exp);
            check({tag, " pulses"}, {rise, fall, hold}, 6'h00);
        end
    endtask

    initial begin
        // 1: reset with inputs already high, simultaneous release.
        rst_s_n = 1'b0;
        din     = 2'b11;
        din_al  = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1 in reset", {dout, rise, fall, hold}, 8'h00);
            check("t1 in reset al", {dout_al, rise_al, fall_al, hold_al}, 8'h00);
        end
        rst_s_n = 1'b1;
        expect_commit("t1 exit", 1'b0, 6, 2'b00, 2'b11, 2'b11, 2'b00);
        expect_hold("t1 long", 6, 2'b11);
        quiet("t1 no repeat", 4, 2'b11);
        check("t1 al idle", dout_al, 2'b00);
        din = 2'b00;
        expect_commit("t1 release", 1'b0, 6, 2'b11, 2'b00, 2'b00, 2'b11);
        quiet("t1 settle", 2, 2'b00);

        // 2 + 4: clean press on ch0, hold once, release, re-press holds again.
        din = 2'b01;
        expect_commit("t2 press", 1'b0, 6, 2'b00, 2'b01, 2'b01, 2'b00);
        expect_hold("t4 hold", 6, 2'b01);
        quiet("t4 no repeat", 5, 2'b01);
        din = 2'b00;
        expect_commit("t4 release", 1'b0, 6, 2'b01, 2'b00, 2'b00, 2'b01);
        din = 2'b01;
        expect_commit("t4 repress", 1'b0, 6, 2'b00, 2'b01, 2'b01, 2'b00);
        expect_hold("t4 rehold", 6, 2'b01);
        din = 2'b00;
        expect_commit("t4 rerelease", 1'b0, 6, 2'b01, 2'b00, 2'b00, 2'b01);
        quiet("t4 settle", 2, 2'b00);

        // 3: 3-cycle glitch rejected, 4-cycle pulse commits.
        din = 2'b01;
        quiet("t3 glitch on", 3, 2'b00);
        din = 2'b00;
        quiet("t3 glitch off", 8, 2'b00);
        din = 2'b01;
        quiet("t3 pulse4 on", 4, 2'b00);
        din = 2'b00;
        expect_commit("t3 pulse4 rise", 1'b0, 2, 2'b00, 2'b01, 2'b01, 2'b00);
        expect_commit("t3 pulse4 fall", 1'b0, 4, 2'b01, 2'b00, 2'b00, 2'b01);
        quiet("t3 settle", 3, 2'b00);

        // 5: reset on the edge that would have committed ch1.
        din = 2'b10;
        quiet("t5 counting", 5, 2'b00);
        rst_s_n = 1'b0;
        tick();
        check("t5 reset edge", {dout, rise, fall, hold}, 8'h00);
        rst_s_n = 1'b1;
        expect_commit("t5 fresh", 1'b0, 6, 2'b00, 2'b10, 2'b10, 2'b00);
        expect_hold("t5 hold", 6, 2'b10);
        din = 2'b00;
        expect_commit("t5 release", 1'b0, 6, 2'b10, 2'b00, 2'b00, 2'b10);

        // 6: idle-high instance.
        check("t6 idle", dout_al, 2'b00);
        din_al = 2'b10;
        expect_commit("t6 press0", 1'b1, 6, 2'b00, 2'b01, 2'b01, 2'b00);
        din_al = 2'b11;
        expect_commit("t6 release0", 1'b1, 6, 2'b01, 2'b00, 2'b00, 2'b01);
        din_al = 2'b00;
        expect_commit("t6 press both", 1'b1, 6, 2'b00, 2'b11, 2'b11, 2'b00);
        din_al = 2'b11;
        expect_commit("t6 release both", 1'b1, 6, 2'b11, 2'b00, 2'b00, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
